// File: rtl/cpu_defs_pkg.sv
// Shared pipeline types for the memory stage: operand widths, memory op
// encodings and the memory-stage FSM states, plus small op-decode helpers.
package cpu_defs;

   typedef logic [31:0] u32_t;
   typedef logic [4:0]  reg_idx_t;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LBU  = 4'd2,
      MEM_LH   = 4'd3,
      MEM_LHU  = 4'd4,
      MEM_LW   = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } mem_size_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_CANCEL = 3'd4
   } mem_stage_state_t;

   function automatic logic op_is_mem(input mem_op_t op);
      return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) || (op == MEM_LHU) ||
             (op == MEM_LW) || (op == MEM_SB)  || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic logic op_is_store(input mem_op_t op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic mem_size_t op_size(input mem_op_t op);
      mem_size_t s;
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: s = SIZE_B;
         MEM_LH, MEM_LHU, MEM_SH: s = SIZE_H;
         default:                 s = SIZE_W;
      endcase
      return s;
   endfunction

   // Only memory ops can be misaligned; ALU results are never checked.
   function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] a);
      logic m;
      m = 1'b0;
      if (op_is_mem(op)) begin
         case (op_size(op))
            SIZE_H:  m = a[0];
            SIZE_W:  m = (a != 2'b00);
            default: m = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the raw cache
// word and sign- or zero-extends it according to the load op.
module load_align
   import cpu_defs::*;
(
   input  mem_op_t    op_i,
   input  logic [1:0] addr_i,
   input  u32_t       rdata_i,
   output u32_t       data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
      half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (op_i)
         MEM_LB:  data_o = {{24{byte_lane[7]}}, byte_lane};
         MEM_LBU: data_o = {24'd0, byte_lane};
         MEM_LH:  data_o = {{16{half_lane[15]}}, half_lane};
         MEM_LHU: data_o = {16'd0, half_lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: latches the EX bundle, issues one data-cache request for
// aligned loads/stores and hands a writeback bundle to WB.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a held bundle stays stable until
// it is taken. The cache request likewise holds addr/size/wr/wstrb/wdata
// steady while dc_req_o is high until dc_addr_ok_i.
module mem_stage
   import cpu_defs::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,

   input  logic     ex_valid_i,
   output logic     ex_ready_o,
   input  mem_op_t  ex_mem_op_i,
   input  u32_t     ex_result_i,
   input  u32_t     ex_store_data_i,
   input  reg_idx_t ex_rd_i,
   input  logic     ex_we_i,
   input  u32_t     ex_pc_i,

   output logic       dc_req_o,
   output logic       dc_wr_o,
   output logic [1:0] dc_size_o,
   output logic [3:0] dc_wstrb_o,
   output u32_t       dc_addr_o,
   output u32_t       dc_wdata_o,
   input  logic       dc_addr_ok_i,
   input  logic       dc_data_ok_i,
   input  u32_t       dc_rdata_i,

   output logic     wb_valid_o,
   input  logic     wb_ready_i,
   output u32_t     wb_data_o,
   output reg_idx_t wb_rd_o,
   output logic     wb_we_o,
   output u32_t     wb_pc_o,
   output logic     wb_ale_o
);

   mem_stage_state_t state_q, state_d;
   mem_op_t          op_q, op_d;
   u32_t             addr_q, addr_d;
   u32_t             sdata_q, sdata_d;
   reg_idx_t         rd_q, rd_d;
   logic             we_q, we_d;
   u32_t             pc_q, pc_d;
   u32_t             wb_data_q, wb_data_d;
   logic             ale_q, ale_d;

   u32_t      load_val;
   mem_size_t size_q;
   logic      in_req;
   logic      accept;
   logic      start;
   logic      mis;

   load_align u_load_align (
      .op_i    (op_q),
      .addr_i  (addr_q[1:0]),
      .rdata_i (dc_rdata_i),
      .data_o  (load_val)
   );

   assign ex_ready_o = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && wb_ready_i));
   assign accept     = ex_valid_i && ex_ready_o;
   assign mis        = op_misaligned(ex_mem_op_i, ex_result_i[1:0]);

   // Request side is driven purely from the held bundle, so it is stable in REQ.
   assign in_req   = (state_q == ST_REQ);
   assign size_q   = op_size(op_q);
   assign dc_req_o = in_req;
   assign dc_wr_o  = in_req && op_is_store(op_q);
   assign dc_size_o = in_req ? size_q : 2'd0;
   assign dc_addr_o = in_req ? addr_q : 32'd0;

   always_comb begin
      dc_wstrb_o = 4'b0000;
      dc_wdata_o = 32'd0;
      if (dc_wr_o) begin
         case (size_q)
            SIZE_B: begin
               dc_wstrb_o = 4'b0001 << addr_q[1:0];
               dc_wdata_o = {4{sdata_q[7:0]}};
            end
            SIZE_H: begin
               dc_wstrb_o = addr_q[1] ? 4'b1100 : 4'b0011;
               dc_wdata_o = {2{sdata_q[15:0]}};
            end
            default: begin
               dc_wstrb_o = 4'b1111;
               dc_wdata_o = sdata_q;
            end
         endcase
      end
   end

   assign wb_valid_o = (state_q == ST_DONE);
   assign wb_data_o  = wb_data_q;
   assign wb_rd_o    = rd_q;
   assign wb_we_o    = we_q;
   assign wb_pc_o    = pc_q;
   assign wb_ale_o   = ale_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      sdata_d   = sdata_q;
      rd_d      = rd_q;
      we_d      = we_q;
      pc_d      = pc_q;
      wb_data_d = wb_data_q;
      ale_d     = ale_q;
      start     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) start = 1'b1;
         end
         ST_REQ: begin
            if (flush) begin
               // An accepted request whose response is still pending must be drained.
               state_d = (dc_addr_ok_i && !dc_data_ok_i) ? ST_CANCEL : ST_IDLE;
            end else if (dc_addr_ok_i) begin
               if (dc_data_ok_i) begin
                  state_d = ST_DONE;
                  if (!op_is_store(op_q)) wb_data_d = load_val;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (dc_data_ok_i) begin
               state_d = flush ? ST_IDLE : ST_DONE;
               if (!flush && !op_is_store(op_q)) wb_data_d = load_val;
            end else if (flush) begin
               state_d = ST_CANCEL;
            end
         end
         ST_DONE: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (wb_ready_i) begin
               state_d = ST_IDLE;
               if (accept) start = 1'b1;
            end
         end
         ST_CANCEL: begin
            if (dc_data_ok_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (start) begin
         op_d      = ex_mem_op_i;
         addr_d    = ex_result_i;
         sdata_d   = ex_store_data_i;
         rd_d      = ex_rd_i;
         pc_d      = ex_pc_i;
         wb_data_d = ex_result_i;
         ale_d     = mis;
         we_d      = ex_we_i && !mis && !op_is_store(ex_mem_op_i);
         state_d   = (mis || !op_is_mem(ex_mem_op_i)) ? ST_DONE : ST_REQ;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= MEM_NONE;
         addr_q    <= 32'd0;
         sdata_q   <= 32'd0;
         rd_q      <= 5'd0;
         we_q      <= 1'b0;
         pc_q      <= 32'd0;
         wb_data_q <= 32'd0;
         ale_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         sdata_q   <= sdata_d;
         rd_q      <= rd_d;
         we_q      <= we_d;
         pc_q      <= pc_d;
         wb_data_q <= wb_data_d;
         ale_q     <= ale_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a vector table of single transactions against a small
// scripted cache, plus hand sequences for stall, flush and reset corners.
module tb_mem_stage;
   import cpu_defs::*;

   logic     clk, rst, flush;
   logic     ex_valid_i, ex_ready_o;
   mem_op_t  ex_mem_op_i;
   u32_t     ex_result_i, ex_store_data_i, ex_pc_i;
   reg_idx_t ex_rd_i;
   logic     ex_we_i;
   logic       dc_req_o, dc_wr_o;
   logic [1:0] dc_size_o;
   logic [3:0] dc_wstrb_o;
   u32_t       dc_addr_o, dc_wdata_o, dc_rdata_i;
   logic       dc_addr_ok_i, dc_data_ok_i;
   logic     wb_valid_o, wb_ready_i, wb_we_o, wb_ale_o;
   u32_t     wb_data_o, wb_pc_o;
   reg_idx_t wb_rd_o;

   int tests = 0;
   int fails = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_mem_op_i(ex_mem_op_i),
      .ex_result_i(ex_result_i), .ex_store_data_i(ex_store_data_i), .ex_rd_i(ex_rd_i),
      .ex_we_i(ex_we_i), .ex_pc_i(ex_pc_i),
      .dc_req_o(dc_req_o), .dc_wr_o(dc_wr_o), .dc_size_o(dc_size_o), .dc_wstrb_o(dc_wstrb_o),
      .dc_addr_o(dc_addr_o), .dc_wdata_o(dc_wdata_o), .dc_addr_ok_i(dc_addr_ok_i),
      .dc_data_ok_i(dc_data_ok_i), .dc_rdata_i(dc_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
      .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_pc_o(wb_pc_o), .wb_ale_o(wb_ale_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      mem_op_t    op;
      u32_t       result;
      u32_t       sdata;
      u32_t       rdata;
      int         aok_dly;
      int         dok_dly;
      logic       exp_req;
      logic       exp_wr;
      logic [1:0] exp_size;
      logic [3:0] exp_wstrb;
      u32_t       exp_wdata;
      logic       chk_data;
      u32_t       exp_data;
      logic       exp_we;
      logic       exp_ale;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input mem_op_t op, input u32_t result, input u32_t sdata,
                               input u32_t rdata, input int aok, input int dok,
                               input logic req, input logic wr, input logic [1:0] size,
                               input logic [3:0] wstrb, input u32_t wdata, input logic cd,
                               input u32_t data, input logic we, input logic ale);
      vec_t v;
      v.op = op; v.result = result; v.sdata = sdata; v.rdata = rdata;
      v.aok_dly = aok; v.dok_dly = dok; v.exp_req = req; v.exp_wr = wr;
      v.exp_size = size; v.exp_wstrb = wstrb; v.exp_wdata = wdata; v.chk_data = cd;
      v.exp_data = data; v.exp_we = we; v.exp_ale = ale;
      return v;
   endfunction

   task automatic drive_ex(input mem_op_t op, input u32_t result, input u32_t sdata,
                           input reg_idx_t rd, input u32_t pc);
      ex_valid_i = 1'b1; ex_mem_op_i = op; ex_result_i = result;
      ex_store_data_i = sdata; ex_rd_i = rd; ex_we_i = 1'b1; ex_pc_i = pc;
   endtask

   // One transaction: drive, play the cache, check the request and the WB bundle.
   task automatic run_vec(input int idx, input vec_t v);
      logic       saw_req, done, unstable;
      logic [39:0] first_req;
      int         aok_cnt, dok_cnt, lat;
      reg_idx_t   rd;
      u32_t       pc;
      saw_req = 0; done = 0; unstable = 0; first_req = '0;
      aok_cnt = 0; dok_cnt = -1; lat = -1;
      rd = reg_idx_t'(idx + 2);
      pc = 32'h1C00_0000 + 32'(idx * 4);
      @(negedge clk);
      wb_ready_i = 1'b1;
      drive_ex(v.op, v.result, v.sdata, rd, pc);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ex_valid_i = 1'b0; dc_addr_ok_i = 1'b0; dc_data_ok_i = 1'b0; dc_rdata_i = 32'h5A5A_5A5A;
         if (wb_valid_o) begin
            done = 1; lat = c;
            break;
         end
         if (dok_cnt > 0) begin
            dok_cnt--;
            if (dok_cnt == 0) begin
               dc_data_ok_i = 1'b1; dc_rdata_i = v.rdata;
            end
         end else if (dc_req_o) begin
            if (!saw_req) begin
               first_req = {dc_wr_o, dc_size_o, dc_wstrb_o, dc_addr_o, 1'b0};
               chk($sformatf("v%0d req_addr", idx), dc_addr_o, v.result);
               chk($sformatf("v%0d req_wr", idx), 32'(dc_wr_o), 32'(v.exp_wr));
               chk($sformatf("v%0d req_size", idx), 32'(dc_size_o), 32'(v.exp_size));
               if (v.exp_wr) begin
                  chk($sformatf("v%0d req_wstrb", idx), 32'(dc_wstrb_o), 32'(v.exp_wstrb));
                  chk($sformatf("v%0d req_wdata", idx), dc_wdata_o, v.exp_wdata);
               end
            end else if (first_req != {dc_wr_o, dc_size_o, dc_wstrb_o, dc_addr_o, 1'b0}) begin
               unstable = 1;
            end
            saw_req = 1;
            if (aok_cnt == v.aok_dly) begin
               dc_addr_ok_i = 1'b1;
               if (v.dok_dly == 0) begin
                  dc_data_ok_i = 1'b1; dc_rdata_i = v.rdata;
               end else begin
                  dok_cnt = v.dok_dly;
               end
            end
            aok_cnt++;
         end
      end
      chk($sformatf("v%0d wb_valid_seen", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d req_issued", idx), 32'(saw_req), 32'(v.exp_req));
      if (v.exp_req) chk($sformatf("v%0d req_stable", idx), 32'(unstable), 32'd0);
      else chk($sformatf("v%0d latency", idx), lat, 32'd0);
      if (v.chk_data) chk($sformatf("v%0d wb_data", idx), wb_data_o, v.exp_data);
      chk($sformatf("v%0d wb_we", idx), 32'(wb_we_o), 32'(v.exp_we));
      chk($sformatf("v%0d wb_ale", idx), 32'(wb_ale_o), 32'(v.exp_ale));
      chk($sformatf("v%0d wb_rd", idx), 32'(wb_rd_o), 32'(rd));
      chk($sformatf("v%0d wb_pc", idx), wb_pc_o, pc);
      chk($sformatf("v%0d ex_ready_in_done", idx), 32'(ex_ready_o), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d retired", idx), 32'(wb_valid_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ex_valid_i = 1'b0; ex_mem_op_i = MEM_NONE;
      ex_result_i = '0; ex_store_data_i = '0; ex_rd_i = '0; ex_we_i = 1'b0; ex_pc_i = '0;
      dc_addr_ok_i = 1'b0; dc_data_ok_i = 1'b0; dc_rdata_i = '0; wb_ready_i = 1'b1;

      //            op       result        sdata         rdata        aok dok req wr size  wstrb    wdata        cd  data          we ale
      vecs[0]  = mk(MEM_NONE, 32'h1234_5678, 32'h0,         32'h0,         0, 0, 0, 0, 2'd0, 4'b0000, 32'h0,         1, 32'h1234_5678, 1, 0);
      vecs[1]  = mk(MEM_LB,   32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 3, 1, 0, 2'd0, 4'b0000, 32'h0,         1, 32'hFFFF_FF80, 1, 0);
      vecs[2]  = mk(MEM_LBU,  32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 3, 1, 0, 2'd0, 4'b0000, 32'h0,         1, 32'h0000_0080, 1, 0);
      vecs[3]  = mk(MEM_SH,   32'h0000_2002, 32'hABCD_1234, 32'h0,         0, 1, 1, 1, 2'd1, 4'b1100, 32'h1234_1234, 0, 32'h0,         0, 0);
      vecs[4]  = mk(MEM_LW,   32'h0000_3001, 32'h0,         32'h0,         0, 0, 0, 0, 2'd0, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
      vecs[5]  = mk(MEM_LH,   32'h0000_1002, 32'h0,         32'h8001_7FFF, 1, 1, 1, 0, 2'd1, 4'b0000, 32'h0,         1, 32'hFFFF_8001, 1, 0);
      vecs[6]  = mk(MEM_LHU,  32'h0000_1002, 32'h0,         32'h8001_7FFF, 0, 2, 1, 0, 2'd1, 4'b0000, 32'h0,         1, 32'h0000_8001, 1, 0);
      vecs[7]  = mk(MEM_LW,   32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 2, 0, 1, 0, 2'd2, 4'b0000, 32'h0,         1, 32'hDEAD_BEEF, 1, 0);
      vecs[8]  = mk(MEM_SB,   32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 1, 1, 1, 2'd0, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0,         0, 0);
      vecs[9]  = mk(MEM_SW,   32'h0000_0008, 32'hCAFE_F00D, 32'h0,         1, 0, 1, 1, 2'd2, 4'b1111, 32'hCAFE_F00D, 0, 32'h0,         0, 0);
      vecs[10] = mk(MEM_LH,   32'h0000_1001, 32'h0,         32'h0,         0, 0, 0, 0, 2'd0, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
      vecs[11] = mk(MEM_LB,   32'h0000_1000, 32'h0,         32'h1234_567F, 0, 1, 1, 0, 2'd0, 4'b0000, 32'h0,         1, 32'h0000_007F, 1, 0);
      vecs[12] = mk(MEM_LBU,  32'h0000_1002, 32'h0,         32'h12AB_5678, 0, 1, 1, 0, 2'd0, 4'b0000, 32'h0,         1, 32'h0000_00AB, 1, 0);

      repeat (2) @(negedge clk);
      chk("reset ex_ready", 32'(ex_ready_o), 32'd1);
      chk("reset wb_valid", 32'(wb_valid_o), 32'd0);
      chk("reset dc_req", 32'(dc_req_o), 32'd0);
      chk("reset wb_bundle", wb_data_o | wb_pc_o | 32'(wb_rd_o) | 32'(wb_we_o) | 32'(wb_ale_o), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // WB stall for four cycles, then back-to-back accept on the release cycle.
      @(negedge clk);
      wb_ready_i = 1'b0;
      drive_ex(MEM_NONE, 32'hA5A5_0001, 32'h0, 5'd3, 32'h1C00_1000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive_ex(MEM_NONE, 32'h0BAD_F00D, 32'h0, 5'd7, 32'h1C00_1004);
         chk($sformatf("stall%0d wb_valid", k), 32'(wb_valid_o), 32'd1);
         chk($sformatf("stall%0d wb_data", k), wb_data_o, 32'hA5A5_0001);
         chk($sformatf("stall%0d wb_rd", k), 32'(wb_rd_o), 32'd3);
         chk($sformatf("stall%0d ex_ready", k), 32'(ex_ready_o), 32'd0);
      end
      wb_ready_i = 1'b1;
      #1 chk("stall release ex_ready", 32'(ex_ready_o), 32'd1);
      @(negedge clk);
      ex_valid_i = 1'b0;
      chk("b2b wb_valid", 32'(wb_valid_o), 32'd1);
      chk("b2b wb_data", wb_data_o, 32'h0BAD_F00D);
      chk("b2b wb_rd", 32'(wb_rd_o), 32'd7);
      @(negedge clk);
      chk("b2b retired", 32'(wb_valid_o), 32'd0);

      // Flush while waiting for data: response must be drained, never written back.
      drive_ex(MEM_LW, 32'h0000_1000, 32'h0, 5'd9, 32'h1C00_2000);
      @(negedge clk);
      ex_valid_i = 1'b0;
      chk("fw req", 32'(dc_req_o), 32'd1);
      dc_addr_ok_i = 1'b1;
      @(negedge clk);
      dc_addr_ok_i = 1'b0;
      flush = 1'b1;
      #1 chk("fw ex_ready_flush", 32'(ex_ready_o), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("fw cancel ex_ready", 32'(ex_ready_o), 32'd0);
      chk("fw cancel wb_valid", 32'(wb_valid_o), 32'd0);
      chk("fw cancel dc_req", 32'(dc_req_o), 32'd0);
      @(negedge clk);
      dc_data_ok_i = 1'b1; dc_rdata_i = 32'h7777_7777;
      #1 chk("fw data_ok ex_ready", 32'(ex_ready_o), 32'd0);
      @(negedge clk);
      dc_data_ok_i = 1'b0;
      #1 chk("fw idle ex_ready", 32'(ex_ready_o), 32'd1);
      chk("fw idle wb_valid", 32'(wb_valid_o), 32'd0);

      // Flush in REQ without addr_ok withdraws the request.
      drive_ex(MEM_LW, 32'h0000_1000, 32'h0, 5'd9, 32'h1C00_2004);
      @(negedge clk);
      ex_valid_i = 1'b0;
      chk("fr req", 32'(dc_req_o), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 chk("fr withdrawn", 32'(dc_req_o), 32'd0);
      chk("fr ex_ready", 32'(ex_ready_o), 32'd1);
      chk("fr wb_valid", 32'(wb_valid_o), 32'd0);

      // Asynchronous reset in REQ drops the request immediately.
      @(negedge clk);
      drive_ex(MEM_LW, 32'h0000_1000, 32'h0, 5'd9, 32'h1C00_2008);
      @(negedge clk);
      ex_valid_i = 1'b0;
      chk("rst req", 32'(dc_req_o), 32'd1);
      #2 rst = 1'b1;
      #1 chk("rst async dc_req", 32'(dc_req_o), 32'd0);
      chk("rst async ex_ready", 32'(ex_ready_o), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst after wb_valid", 32'(wb_valid_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage LoongArch pipeline. Sits directly downstream of the execute-stage ALU.
- Consumes the EX result: the ALU sum is the load/store effective address, or it is the writeback value for non-memory ops.
- For memory ops, issues one data-cache request over a req/addr_ok/data_ok handshake and waits for the response. Load data is byte-aligned and sign/zero-extended.
- Presents a writeback bundle to WB over a valid/ready handshake.

Parameters:
- none; widths come from the shared package (u32_t, reg_idx_t = 5 bits).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill in-flight instruction (exception/branch redirect)
- ex_valid_i  in  1  EX bundle valid
- ex_ready_o  out  1  stage can accept EX bundle this cycle
- ex_mem_op_i  in  mem_op_t (4)  NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
- ex_result_i  in  32  ALU output: address or writeback value
- ex_store_data_i  in  32  rk value for stores
- ex_rd_i  in  5  destination register
- ex_we_i  in  1  instruction writes rd
- ex_pc_i  in  32  instruction PC
- dc_req_o  out  1  cache request valid
- dc_wr_o  out  1  1 = store
- dc_size_o  out  2  0 = byte, 1 = half, 2 = word
- dc_wstrb_o  out  4  byte enables
- dc_addr_o  out  32  request address
- dc_wdata_o  out  32  store data, lane-replicated
- dc_addr_ok_i  in  1  request accepted
- dc_data_ok_i  in  1  response (loads and stores)
- dc_rdata_i  in  32  raw aligned word
- wb_valid_o  out  1  bundle valid
- wb_ready_i  in  1  WB accepts
- wb_data_o  out  32  writeback value
- wb_rd_o  out  5  destination
- wb_we_o  out  1  register write enable
- wb_pc_o  out  32  PC
- wb_ale_o  out  1  address-misaligned exception

Behaviour:
- Reset: state IDLE; every output 0, except ex_ready_o = 1 (combinational from IDLE). Held bundle registers cleared.
- States:
  - IDLE
  - REQ: dc_req_o high, waiting for addr_ok
  - WAIT: waiting for data_ok
  - DONE: wb_valid_o high
  - CANCEL: draining an orphaned response
- Accept:
  - ex_ready_o = !flush && (IDLE || (DONE && wb_ready_i)).
  - Accept when ex_valid_i && ex_ready_o; the bundle is latched on that edge.
- Non-memory op (NONE): accept -> DONE next cycle with wb_data = ex_result. Latency 1.
- Misalignment check at accept: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Misaligned: -> DONE, wb_ale = 1, wb_we = 0, no cache request.
- Aligned mem op: accept -> REQ.
  - REQ: dc_req_o = 1 with stable addr/size/wr/wstrb/wdata until addr_ok. On addr_ok -> WAIT. addr_ok and data_ok in the same cycle -> DONE directly.
  - WAIT: on data_ok -> DONE, with extracted load data latched. Minimum latency 2 cycles (accept-to-DONE) with zero-wait cache.
- Store encoding:
  - wstrb: SB = 0001 << addr[1:0]; SH = 0011 << {addr[1],0}; SW = 1111.
  - wdata: byte replicated x4, half replicated x2.
  - Stores: wb_we = 0.
- Load extract: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- DONE: hold all wb_* stable until wb_ready_i. Back-to-back accept in the same cycle allowed.
- Flush (highest priority):
  - IDLE/DONE -> IDLE, wb_valid 0.
  - REQ without addr_ok this cycle -> IDLE; request withdrawn.
  - REQ with addr_ok, or WAIT without data_ok -> CANCEL.
  - WAIT with data_ok -> IDLE.
  - CANCEL: no request, ex_ready_o = 0; on data_ok -> IDLE, data discarded.
- Async reset mid-request: immediate IDLE; the cache side is reset by the same rst.

Decomposition:
- Shared package cpu_defs: mem_op_t enum, mem_size_t, u32_t, reg_idx_t, mem_stage_state_t.
- One sub-module, load_align: combinational lane select plus extension (op, addr[1:0], rdata -> 32-bit value).
- Store wstrb/wdata generation stays inline.

Test Plan:
- ALU op, ex_result = 0x1234_5678, rd = 5, wb_ready = 1 -> next cycle wb_valid = 1, wb_data = 0x1234_5678, wb_we = 1; ex_ready stays 1.
- LB addr 0x1003, cache addr_ok immediate, data_ok 3 cycles later with rdata = 0x80FF_0000 -> wb_data = 0xFFFF_FF80.
- LBU same stimulus -> wb_data = 0x0000_0080.
- SH addr 0x2002, data 0xABCD_1234 -> dc_wstrb = 1100, dc_wdata = 0x1234_1234, dc_wr = 1; wb_we = 0 after data_ok.
- LW addr 0x3001 -> no dc_req_o ever; wb_ale = 1, wb_we = 0 next cycle.
- LW accepted, addr_ok given, flush in WAIT, data_ok 2 cycles later -> no wb_valid; ex_ready = 0 until data_ok, then 1.
- wb_ready held 0 for 4 cycles in DONE -> wb_* stable, ex_ready = 0.
- Assert rst while in REQ -> dc_req_o = 0 immediately.
